// File: rtl/block_xfer_sequencer_pkg.sv
// rtl/block_xfer_sequencer_pkg.sv - shared types and constants for the block transfer sequencer
package block_xfer_sequencer_pkg;

  localparam int LINE_WORDS   = 16;
  localparam int WORD_W       = 32;
  localparam int PIX_PER_BLK  = 64;
  localparam int PIX_PER_WORD = 4;
  localparam int LINES_W      = LINE_WORDS * WORD_W;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FILL     = 3'd1,
    ST_PRESENT  = 3'd2,
    ST_CAPTURE  = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_WAIT_ACK = 3'd5
  } seq_state_e;

  // Bit position of the LSB of pixel pix_idx inside the packed line vector.
  // The first pixel of each word occupies the most significant byte.
  function automatic logic [8:0] byte_lsb(input logic [5:0] pix_idx);
    int word_idx;
    int lane;
    word_idx = int'(pix_idx) / PIX_PER_WORD;
    lane     = int'(pix_idx) % PIX_PER_WORD;
    return 9'(word_idx * WORD_W + (PIX_PER_WORD - 1 - lane) * 8);
  endfunction

endpackage

// File: rtl/block_word_packer.sv
// rtl/block_word_packer.sv - packs 64 raster pixels into the 16-word line register file
module block_word_packer
  import block_xfer_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               clear,
  input  logic [7:0]         pix_data,
  output logic [LINES_W-1:0] lines,
  output logic               last_pix,
  output logic               full
);

  localparam logic [5:0] LAST_IDX = 6'(PIX_PER_BLK - 1);

  logic [5:0]         cnt_q, cnt_d;
  logic [LINES_W-1:0] lines_q, lines_d;
  logic               full_q, full_d;

  // Next-state: clear wins over load; a load writes one byte lane and advances the count.
  always_comb begin
    cnt_d   = cnt_q;
    lines_d = lines_q;
    full_d  = full_q;
    if (clear) begin
      cnt_d  = '0;
      full_d = 1'b0;
    end else if (load) begin
      lines_d[byte_lsb(cnt_q) +: 8] = pix_data;
      cnt_d = cnt_q + 6'd1;
      if (cnt_q == LAST_IDX) begin
        full_d = 1'b1;
      end
    end
  end

  // Register the pixel count, the line words and the full flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      lines_q <= '0;
      full_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
      full_q  <= full_d;
    end
  end

  assign lines    = lines_q;
  assign last_pix = (cnt_q == LAST_IDX);
  assign full     = full_q;

endmodule

// File: rtl/block_xfer_sequencer.sv
// rtl/block_xfer_sequencer.sv - sequences 8x8 pixel blocks to the CPU and streams back result words
module block_xfer_sequencer
  import block_xfer_sequencer_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int TIMEOUT = 65535
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [PIX_W-1:0]   pix_in_data,
  input  logic               pix_in_valid,
  output logic               pix_in_ready,
  output logic [LINES_W-1:0] lines_in,
  output logic               blk_ready,
  input  logic               cpu_done,
  input  logic [LINES_W-1:0] lines_out,
  output logic [WORD_W-1:0]  coef_out_data,
  output logic               coef_out_valid,
  output logic               coef_out_last,
  input  logic               coef_out_ready,
  output logic               busy,
  output logic               timeout_err,
  input  logic               err_clr
);

  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [3:0]  LAST_BEAT = 4'(LINE_WORDS - 1);

  seq_state_e         state_q, state_d;
  logic               pix_in_ready_q, pix_in_ready_d;
  logic               blk_ready_q, blk_ready_d;
  logic               coef_valid_q, coef_valid_d;
  logic [3:0]         beat_q, beat_d;
  logic [15:0]        tmo_q, tmo_d;
  logic               timeout_err_q, timeout_err_d;
  logic [LINES_W-1:0] res_buf_q, res_buf_d;

  logic               tmo_set;
  logic               pk_load;
  logic               pk_clear;
  logic               pk_last;
  logic               pk_full;

  block_word_packer u_packer (
    .clk      (clk),
    .reset    (reset),
    .load     (pk_load),
    .clear    (pk_clear),
    .pix_data (pix_in_data),
    .lines    (lines_in),
    .last_pix (pk_last),
    .full     (pk_full)
  );

  // Sequencer next-state: block handshake with the CPU, timeout recovery and result drain.
  always_comb begin
    state_d        = state_q;
    pix_in_ready_d = pix_in_ready_q;
    blk_ready_d    = blk_ready_q;
    coef_valid_d   = coef_valid_q;
    beat_d         = beat_q;
    tmo_d          = tmo_q;
    res_buf_d      = res_buf_q;
    tmo_set        = 1'b0;
    pk_clear       = 1'b0;
    pk_load        = (state_q == ST_FILL) && pix_in_valid && pix_in_ready_q && !pk_full;

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d        = ST_FILL;
          pix_in_ready_d = 1'b1;
        end
      end
      ST_FILL: begin
        if (pk_load && pk_last) begin
          state_d        = ST_PRESENT;
          pix_in_ready_d = 1'b0;
          blk_ready_d    = 1'b1;
          tmo_d          = '0;
        end
      end
      ST_PRESENT: begin
        if (cpu_done) begin
          state_d     = ST_CAPTURE;
          blk_ready_d = 1'b0;
          tmo_d       = '0;
        end else if (tmo_q == TMO_LAST) begin
          // CPU never answered: flag it, drop the block and start refilling from pixel 0.
          tmo_set        = 1'b1;
          pk_clear       = 1'b1;
          blk_ready_d    = 1'b0;
          pix_in_ready_d = 1'b1;
          tmo_d          = '0;
          state_d        = ST_FILL;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      ST_CAPTURE: begin
        res_buf_d    = lines_out;
        pk_clear     = 1'b1;
        beat_d       = '0;
        coef_valid_d = 1'b1;
        state_d      = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (coef_valid_q && coef_out_ready) begin
          if (beat_q == LAST_BEAT) begin
            coef_valid_d = 1'b0;
            beat_d       = '0;
            if (cpu_done) begin
              state_d = ST_WAIT_ACK;
            end else if (!enable) begin
              state_d = ST_IDLE;
            end else begin
              state_d        = ST_FILL;
              pix_in_ready_d = 1'b1;
            end
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end
      ST_WAIT_ACK: begin
        // A done level left over from this block must drop before another block may start.
        if (!cpu_done) begin
          if (enable) begin
            state_d        = ST_FILL;
            pix_in_ready_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d        = ST_IDLE;
        pix_in_ready_d = 1'b0;
        blk_ready_d    = 1'b0;
        coef_valid_d   = 1'b0;
      end
    endcase

    if (err_clr) begin
      timeout_err_d = 1'b0;
    end else if (tmo_set) begin
      timeout_err_d = 1'b1;
    end else begin
      timeout_err_d = timeout_err_q;
    end
  end

  // State, registered outputs, counters and the captured result buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      pix_in_ready_q <= 1'b0;
      blk_ready_q    <= 1'b0;
      coef_valid_q   <= 1'b0;
      beat_q         <= '0;
      tmo_q          <= '0;
      timeout_err_q  <= 1'b0;
      res_buf_q      <= '0;
    end else begin
      state_q        <= state_d;
      pix_in_ready_q <= pix_in_ready_d;
      blk_ready_q    <= blk_ready_d;
      coef_valid_q   <= coef_valid_d;
      beat_q         <= beat_d;
      tmo_q          <= tmo_d;
      timeout_err_q  <= timeout_err_d;
      res_buf_q      <= res_buf_d;
    end
  end

  assign pix_in_ready   = pix_in_ready_q;
  assign blk_ready      = blk_ready_q;
  assign coef_out_valid = coef_valid_q;
  assign coef_out_data  = coef_valid_q ? res_buf_q[{beat_q, 5'd0} +: WORD_W] : '0;
  assign coef_out_last  = coef_valid_q && (beat_q == LAST_BEAT);
  assign busy           = (state_q != ST_IDLE);
  assign timeout_err    = timeout_err_q;

endmodule

// File: tb/tb_block_xfer_sequencer.sv
// tb/tb_block_xfer_sequencer.sv - randomized scoreboard bench for block_xfer_sequencer
module tb_block_xfer_sequencer;

  localparam int TMO = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic [7:0]   pix_in_data;
  logic         pix_in_valid;
  logic         pix_in_ready;
  logic [511:0] lines_in;
  logic         blk_ready;
  logic         cpu_done;
  logic [511:0] lines_out;
  logic [31:0]  coef_out_data;
  logic         coef_out_valid;
  logic         coef_out_last;
  logic         coef_out_ready;
  logic         busy;
  logic         timeout_err;
  logic         err_clr;

  always #5 clk = ~clk;

  block_xfer_sequencer #(.PIX_W(8), .TIMEOUT(TMO)) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .pix_in_data    (pix_in_data),
    .pix_in_valid   (pix_in_valid),
    .pix_in_ready   (pix_in_ready),
    .lines_in       (lines_in),
    .blk_ready      (blk_ready),
    .cpu_done       (cpu_done),
    .lines_out      (lines_out),
    .coef_out_data  (coef_out_data),
    .coef_out_valid (coef_out_valid),
    .coef_out_last  (coef_out_last),
    .coef_out_ready (coef_out_ready),
    .busy           (busy),
    .timeout_err    (timeout_err),
    .err_clr        (err_clr)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t      exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;
  int         beats_seen = 0;
  bit         rand_ready = 1'b0;
  logic [7:0] blk_pix [64];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word(input int k);
    return {blk_pix[4*k], blk_pix[4*k+1], blk_pix[4*k+2], blk_pix[4*k+3]};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_lines(input string name);
    for (int k = 0; k < 16; k++) begin
      chk(name, 64'(lines_in[32*k +: 32]), 64'(model_word(k)));
    end
  endtask

  task automatic rand_block();
    for (int i = 0; i < 64; i++) blk_pix[i] = 8'($urandom);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("reset_outputs",
        {16'd0, 8'(|lines_in), blk_ready, pix_in_ready, coef_out_valid, coef_out_last,
         busy, timeout_err, 2'b00, coef_out_data}, 64'd0);
  endtask

  // Offer pixels start..count-1; optionally gate valid and drive junk data when not valid.
  task automatic fill_pixels(input int start, input int count, input bit gate);
    int n;
    int guard;
    bit acc;
    n = start;
    guard = 0;
    while (n < count && guard < 4000) begin
      pix_in_valid = gate ? ($urandom_range(0, 99) < 65) : 1'b1;
      pix_in_data  = pix_in_valid ? blk_pix[n] : 8'($urandom);
      @(negedge clk);
      acc = pix_in_valid && pix_in_ready;
      @(posedge clk);
      #1;
      if (acc) n++;
      guard++;
    end
    pix_in_valid = 1'b0;
    chk("fill_progress", 64'(n), 64'(count));
  endtask

  // Called one cycle after pixel 63 was accepted.
  task automatic present_and_drain(input int delay, input bit directed, input bit hold_done);
    logic [31:0] w;
    chk("blk_ready_latency", 64'(blk_ready), 64'd1);
    check_lines("lines_packing");
    for (int k = 0; k < 16; k++) begin
      w = directed ? (32'hA000_0000 + 32'(k)) : $urandom;
      lines_out[32*k +: 32] = w;
      exp_q.push_back('{data: w, last: (k == 15)});
    end
    pix_in_valid = 1'b1;
    pix_in_data  = 8'hEE;
    tick(delay);
    pix_in_valid = 1'b0;
    chk("blk_ready_hold", 64'(blk_ready), 64'd1);
    check_lines("lines_hold");
    cpu_done = 1'b1;
    tick(1);
    cpu_done = hold_done;
    chk("capture_no_valid", 64'({coef_out_valid, blk_ready}), 64'd0);
    tick(1);
    chk("first_beat_latency", 64'(coef_out_valid), 64'd1);
  endtask

  task automatic wait_drained();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || coef_out_valid) && guard < 500) begin
      tick(1);
      guard++;
    end
    chk("drain_done", 64'(guard < 500), 64'd1);
  endtask

  initial begin
    coef_out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      coef_out_ready = rand_ready ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end
  end

  // Scoreboard monitor: every transferred beat is matched against the expected queue.
  logic        stall_prev = 1'b0;
  logic [31:0] data_prev = '0;
  beat_t       got;
  always @(negedge clk) begin
    if (!reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && coef_out_valid) chk("stall_data_stable", 64'(coef_out_data), 64'(data_prev));
      if (coef_out_valid && coef_out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 64'(coef_out_data), 64'hDEAD_BEEF_0000_0000);
        end else begin
          got = exp_q.pop_front();
          chk("beat_data", 64'(coef_out_data), 64'(got.data));
          chk("beat_last", 64'(coef_out_last), 64'(got.last));
        end
        beats_seen++;
      end
      stall_prev = coef_out_valid && !coef_out_ready;
      data_prev  = coef_out_data;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base;
    int guard;
    reset        = 1'b0;
    enable       = 1'b0;
    pix_in_data  = '0;
    pix_in_valid = 1'b0;
    cpu_done     = 1'b0;
    lines_out    = '0;
    err_clr      = 1'b0;
    tick(3);
    apply_reset();

    // Release with enable high: ready appears on the second cycle.
    enable = 1'b1;
    reset  = 1'b1;
    chk("ready_cycle1", 64'(pix_in_ready), 64'd0);
    tick(1);
    chk("ready_cycle2", 64'({pix_in_ready, busy}), 64'b11);

    // Ramp block and directed result words, done held high into WAIT_ACK.
    for (int i = 0; i < 64; i++) blk_pix[i] = 8'(i);
    fill_pixels(0, 64, 1'b0);
    chk("word0_ramp", 64'(lines_in[31:0]), 64'h0001_0203);
    chk("word15_ramp", 64'(lines_in[511:480]), 64'h3C3D_3E3F);
    present_and_drain(2, 1'b1, 1'b1);
    wait_drained();
    tick(3);
    chk("wait_ack_hold", 64'({busy, pix_in_ready}), 64'b10);
    cpu_done = 1'b0;
    chk("ack_ready_low", 64'(pix_in_ready), 64'd0);
    tick(1);
    chk("ready_after_ack", 64'(pix_in_ready), 64'd1);

    // Random blocks, gated pixel valid, random sink backpressure.
    rand_ready = 1'b1;
    for (int b = 0; b < 6; b++) begin
      rand_block();
      fill_pixels(0, 64, 1'b1);
      present_and_drain($urandom_range(0, 4), 1'b0, 1'b0);
      wait_drained();
    end
    rand_ready = 1'b0;
    tick(1);

    // Timeout with cpu_done withheld.
    rand_block();
    fill_pixels(0, 64, 1'b0);
    tick(TMO - 1);
    chk("no_timeout_yet", 64'({timeout_err, blk_ready}), 64'b01);
    tick(1);
    chk("timeout_fires", 64'({timeout_err, blk_ready, pix_in_ready}), 64'b101);

    // Second timeout coinciding with err_clr: clear wins.
    rand_block();
    fill_pixels(0, 64, 1'b0);
    tick(TMO - 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("clr_beats_set", 64'({timeout_err, blk_ready, pix_in_ready}), 64'b001);

    // Refill starts at pixel 0.
    rand_block();
    fill_pixels(0, 1, 1'b0);
    chk("restart_pixel0", 64'(lines_in[31:24]), 64'(blk_pix[0]));
    fill_pixels(1, 64, 1'b0);
    present_and_drain(1, 1'b0, 1'b0);
    wait_drained();

    // Reset after pixel 37, then a clean block.
    rand_block();
    fill_pixels(0, 37, 1'b0);
    apply_reset();
    tick(2);
    reset = 1'b1;
    rand_block();
    fill_pixels(0, 64, 1'b1);
    present_and_drain(2, 1'b0, 1'b0);
    wait_drained();

    // Reset during drain beat 5; no stale beats afterwards.
    rand_block();
    fill_pixels(0, 64, 1'b0);
    present_and_drain(1, 1'b0, 1'b0);
    base  = beats_seen;
    guard = 0;
    while (beats_seen - base < 5 && guard < 100) begin
      tick(1);
      guard++;
    end
    chk("reached_beat5", 64'(beats_seen - base), 64'd5);
    apply_reset();
    tick(2);
    reset = 1'b1;
    tick(4);
    chk("no_stale_valid", 64'(coef_out_valid), 64'd0);
    rand_block();
    fill_pixels(0, 64, 1'b0);
    present_and_drain(0, 1'b0, 1'b0);
    wait_drained();

    // enable dropped during drain: lands in IDLE.
    rand_block();
    fill_pixels(0, 64, 1'b0);
    present_and_drain(1, 1'b0, 1'b0);
    enable = 1'b0;
    wait_drained();
    chk("idle_after_drain", 64'({busy, pix_in_ready}), 64'b00);
    tick(3);
    chk("idle_stays", 64'({busy, pix_in_ready}), 64'b00);
    enable = 1'b1;
    tick(1);
    chk("idle_to_fill", 64'({busy, pix_in_ready}), 64'b11);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
